tran_4x4_sched: RTL and testbench

Scheduler that shares the single `tran_4x4` forward-transform core between two residual producers: luma (requester 0) and chroma (requester 1). It arbitrates round-robin, stages the granted 4x4 block into a capture register and drives the core's `enable`. It tracks the core's one-cycle result slot and presents tagged coefficients downstream with valid/ready backpressure. It sits between the residual generators and quantisation.

---
 rtl/tran_pkg.sv | 32 +++
 rtl/tran_4x4_sched_if.sv | 35 +++
 rtl/rr_arb2.sv | 33 +++
 rtl/tran_4x4_sched.sv | 120 ++++++++++++
 tb/tb_tran_4x4_sched.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tran_pkg.sv
// Shared types, block-count constants and index helpers for the tran_4x4 scheduler.
// The index helpers are only referenced when TRAN_SCHED_BLKIDX_EN is defined.
package tran_pkg;

    localparam int BIT_LENGTH = 31;
    localparam int NUM_BLK_L  = 16;
    localparam int NUM_BLK_C  = 8;

    localparam logic SRC_LUMA   = 1'b0;
    localparam logic SRC_CHROMA = 1'b1;

    typedef logic        [BIT_LENGTH:0] word_t;
    typedef logic signed [BIT_LENGTH:0] coef_word_t;

    // Raster-ordered 4x4 block: element 0 is row 0, column 0.
    typedef word_t      [15:0] blk_t;
    typedef coef_word_t [15:0] coef_t;

    typedef struct packed {
        logic       src;
        logic [3:0] idx;
    } tag_t;

    function automatic logic [3:0] last_idx(input logic src);
        return (src == SRC_CHROMA) ? 4'(NUM_BLK_C - 1) : 4'(NUM_BLK_L - 1);
    endfunction

    function automatic logic [3:0] next_idx(input logic src, input logic [3:0] idx);
        return (idx == last_idx(src)) ? 4'd0 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/tran_4x4_sched_if.sv
// Request, core and downstream signals of the tran_4x4 scheduler.
// The scheduler takes the slave modport; its environment drives the master modport.
interface tran_4x4_sched_if;
    import tran_pkg::*;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    blk_t       req_res_l;
    blk_t       req_res_c;

    logic       tran_en;
    blk_t       tran_res;
    coef_t      tran_coef;

    logic       out_valid;
    logic       out_ready;
    coef_t      out_coef;
    logic       out_src;
    logic [3:0] out_idx;
    logic       mb_done;
    logic       busy;

    modport slave (
        input  req_valid, req_res_l, req_res_c, tran_coef, out_ready,
        output req_ready, tran_en, tran_res, out_valid, out_coef,
               out_src, out_idx, mb_done, busy
    );

    modport master (
        output req_valid, req_res_l, req_res_c, tran_coef, out_ready,
        input  req_ready, tran_en, tran_res, out_valid, out_coef,
               out_src, out_idx, mb_done, busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last time wins.
// The pointer only moves when the granted request is actually accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid_i,
    input  logic       adv_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        if (&valid_i) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end else begin
            grant_o = valid_i;
        end
    end

    assign last_d = adv_i ? grant_o[1] : last_q;

    // Pointer starts at chroma so luma wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/tran_4x4_sched.sv
// Shares one tran_4x4 core between luma and chroma producers with a two-deep pipeline.
// Define TRAN_SCHED_BLKIDX_EN to build the per-requester block counters, out_idx and mb_done.
module tran_4x4_sched
    import tran_pkg::*;
(
    input logic                    clk,
    input logic                    reset,
    tran_4x4_sched_if.slave        bus
);

    logic       cap_valid_q, cap_valid_d;
    logic       core_full_q, core_full_d;
    blk_t       cap_blk_q,   cap_blk_d;
    tag_t       cap_tag_q,   cap_tag_d;
    tag_t       out_tag_q,   out_tag_d;

    logic       core_free;
    logic       cap_adv;
    logic [1:0] grant;
    logic [1:0] accept;
    logic       acc_any;
    logic       acc_src;
    logic [3:0] acc_idx;

    // The core result slot frees up in the same cycle downstream takes it.
    assign core_free   = ~core_full_q | bus.out_ready;
    assign cap_adv     = cap_valid_q & core_free;
    assign bus.tran_en = cap_adv;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid_i (bus.req_valid),
        .adv_i   (acc_any),
        .grant_o (grant)
    );

    assign bus.req_ready = grant & {2{~cap_valid_q | cap_adv}};
    assign accept        = bus.req_valid & bus.req_ready;
    assign acc_any       = |accept;
    assign acc_src       = accept[1] ? SRC_CHROMA : SRC_LUMA;

`ifdef TRAN_SCHED_BLKIDX_EN
    logic [3:0] cnt_l_q, cnt_l_d;
    logic [3:0] cnt_c_q, cnt_c_d;

    always_comb begin
        cnt_l_d = cnt_l_q;
        cnt_c_d = cnt_c_q;
        if (accept[0]) cnt_l_d = next_idx(SRC_LUMA, cnt_l_q);
        if (accept[1]) cnt_c_d = next_idx(SRC_CHROMA, cnt_c_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_l_q <= 4'd0;
            cnt_c_q <= 4'd0;
        end else begin
            cnt_l_q <= cnt_l_d;
            cnt_c_q <= cnt_c_d;
        end
    end

    assign acc_idx     = (acc_src == SRC_CHROMA) ? cnt_c_q : cnt_l_q;
    assign bus.mb_done = core_full_q & bus.out_ready
                       & (out_tag_q.idx == last_idx(out_tag_q.src));
`else
    assign acc_idx     = 4'd0;
    assign bus.mb_done = 1'b0;
`endif

    // Capture stage: a same-cycle hand-off to the core and a new accept keep it full.
    always_comb begin
        cap_valid_d = cap_valid_q;
        cap_blk_d   = cap_blk_q;
        cap_tag_d   = cap_tag_q;
        if (cap_adv) cap_valid_d = 1'b0;
        if (acc_any) begin
            cap_valid_d = 1'b1;
            cap_blk_d   = (acc_src == SRC_CHROMA) ? bus.req_res_c : bus.req_res_l;
            cap_tag_d   = '{src: acc_src, idx: acc_idx};
        end
    end

    // Core stage: the core holds its output while enable is low, so only the tag is stored here.
    always_comb begin
        core_full_d = core_full_q;
        out_tag_d   = out_tag_q;
        if (cap_adv) begin
            core_full_d = 1'b1;
            out_tag_d   = cap_tag_q;
        end else if (core_full_q & bus.out_ready) begin
            core_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_valid_q <= 1'b0;
            core_full_q <= 1'b0;
            cap_blk_q   <= '0;
            cap_tag_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            core_full_q <= core_full_d;
            cap_blk_q   <= cap_blk_d;
            cap_tag_q   <= cap_tag_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign bus.tran_res  = cap_blk_q;
    assign bus.out_valid = core_full_q;
    assign bus.out_coef  = bus.tran_coef;
    assign bus.out_src   = out_tag_q.src;
    assign bus.out_idx   = out_tag_q.idx;
    assign bus.busy      = cap_valid_q | core_full_q;

endmodule

// File: tb/tb_tran_4x4_sched.sv
// Directed bench for tran_4x4_sched with a behavioural tran_4x4 core and a result scoreboard.
// Honours TRAN_SCHED_BLKIDX_EN when computing expected out_idx and mb_done.
module tb_tran_4x4_sched;
    import tran_pkg::*;

`ifdef TRAN_SCHED_BLKIDX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    typedef struct {
        logic       src;
        logic [3:0] idx;
        int         dc;
        logic       last;
    } exp_t;

    logic clk;
    logic reset;
    tran_4x4_sched_if bus();
    coef_t coreQ;

    int testCount = 0;
    int failCount = 0;
    int nl = 0, nc = 0, tl = 0, tc = 0;
    int cyc = 0, mbCount = 0;
    logic [3:0] eIdxL = 4'd0, eIdxC = 4'd0;
    exp_t sbQ[$];
    int   accLog[$];
    int   outCyc[$];

    tran_4x4_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic blk_t blkFill(input int v);
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = 32'(v);
        return b;
    endfunction

    // Forward 4x4 integer transform Y = Cf * X * Cf^T.
    function automatic coef_t xform(input blk_t x);
        int cf[4][4];
        int t[4][4];
        int s;
        coef_t y;
        cf = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += cf[i][k] * int'(x[k*4+j]);
                t[i][j] = s;
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += t[i][k] * cf[j][k];
                y[i*4+j] = 32'(s);
            end
        return y;
    endfunction

    assign bus.tran_coef = coreQ;

    always @(posedge clk) begin
        if (bus.tran_en) coreQ <= xform(bus.tran_res);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Producers: luma block n is all (n+1), chroma block n is all (500+n).
    initial begin
        bus.req_valid = 2'b00;
        bus.req_res_l = '0;
        bus.req_res_c = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.req_valid[0] = (nl < tl);
            bus.req_valid[1] = (nc < tc);
            bus.req_res_l    = blkFill(nl + 1);
            bus.req_res_c    = blkFill(500 + nc);
        end
    end

    // Scoreboard: accepts push expectations, output handshakes pop and compare.
    always @(negedge clk) begin
        exp_t e;
        logic expMb;
        cyc++;
        if (reset) begin
            sbQ.delete();
            eIdxL = 4'd0;
            eIdxC = 4'd0;
        end else begin
            expMb = 1'b0;
            if (bus.req_valid[0] && bus.req_ready[0]) begin
                e.src  = 1'b0;
                e.idx  = IDX_EN ? eIdxL : 4'd0;
                e.last = IDX_EN && (eIdxL == 4'd15);
                e.dc   = 16 * (nl + 1);
                eIdxL  = (eIdxL == 4'd15) ? 4'd0 : eIdxL + 4'd1;
                sbQ.push_back(e);
                accLog.push_back(0);
                nl++;
            end
            if (bus.req_valid[1] && bus.req_ready[1]) begin
                e.src  = 1'b1;
                e.idx  = IDX_EN ? eIdxC : 4'd0;
                e.last = IDX_EN && (eIdxC == 4'd7);
                e.dc   = 16 * (500 + nc);
                eIdxC  = (eIdxC == 4'd7) ? 4'd0 : eIdxC + 4'd1;
                sbQ.push_back(e);
                accLog.push_back(1);
                nc++;
            end
            if (bus.out_valid && bus.out_ready) begin
                outCyc.push_back(cyc);
                if (sbQ.size() == 0) begin
                    checkOutput("sb_unexpected", 32'(bus.out_valid & bus.out_ready), 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sb_src", 32'(bus.out_src), 32'(e.src));
                    checkOutput("sb_idx", 32'(bus.out_idx), 32'(e.idx));
                    checkOutput("sb_coef0", bus.out_coef[0], 32'(e.dc));
                    checkOutput("sb_coef15", bus.out_coef[15], 32'd0);
                    expMb = e.last;
                end
                if (bus.mb_done) mbCount++;
            end
            checkOutput("mb_done", 32'(bus.mb_done), 32'(expMb));
        end
    end

    task automatic applyStimulus(input int addL, input int addC, input logic rdy);
        @(posedge clk);
        #2;
        tl += addL;
        tc += addC;
        bus.out_ready = rdy;
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int maxCyc);
        int n = 0;
        while ((nl < tl || nc < tc || sbQ.size() != 0) && n < maxCyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 32'(nl >= tl && nc >= tc && sbQ.size() == 0), 32'd1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startL;
        int m0;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_tran_en", 32'(bus.tran_en), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_mb_done", 32'(bus.mb_done), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        $display("[TB] single luma block of ones");
        applyStimulus(1, 0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("t1_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("t1_tran_en0", 32'(bus.tran_en), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("t1_tran_en1", 32'(bus.tran_en), 32'd1);
        checkOutput("t1_out_valid0", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("t1_out_valid1", 32'(bus.out_valid), 32'd1);
        checkOutput("t1_coef0", bus.out_coef[0], 32'd16);
        checkOutput("t1_src", 32'(bus.out_src), 32'd0);
        checkOutput("t1_idx", 32'(bus.out_idx), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("t1_out_valid2", 32'(bus.out_valid), 32'd0);
        checkOutput("t1_busy", 32'(bus.busy), 32'd0);
        waitIdle("t1_idle", 20);

        $display("[TB] both requesters, three blocks each");
        pulseReset();
        accLog.delete();
        outCyc.delete();
        applyStimulus(3, 3, 1'b1);
        waitIdle("t2_idle", 40);
        checkOutput("t2_accepts", 32'(accLog.size()), 32'd6);
        checkOutput("t2_outputs", 32'(outCyc.size()), 32'd6);
        for (int k = 0; k < accLog.size() && k < 6; k++)
            checkOutput("t2_grant_order", 32'(accLog[k]), 32'(k % 2));
        for (int k = 1; k < outCyc.size() && k < 6; k++)
            checkOutput("t2_back_to_back", 32'(outCyc[k] - outCyc[k-1]), 32'd1);

        $display("[TB] backpressure with luma streaming");
        startL = nl;
        applyStimulus(4, 0, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("t3_in_flight", 32'(nl - startL), 32'd2);
        checkOutput("t3_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("t3_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t3_tran_en", 32'(bus.tran_en), 32'd0);
        checkOutput("t3_busy", 32'(bus.busy), 32'd1);
        applyStimulus(0, 0, 1'b1);
        waitIdle("t3_idle", 40);

        $display("[TB] seventeen luma blocks");
        pulseReset();
        m0 = mbCount;
        applyStimulus(17, 0, 1'b1);
        waitIdle("t4_idle", 80);
        checkOutput("t4_mb_pulses", 32'(mbCount - m0), IDX_EN ? 32'd1 : 32'd0);

        $display("[TB] reset with two blocks in flight");
        applyStimulus(2, 0, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("t5_busy_pre", 32'(bus.busy), 32'd1);
        checkOutput("t5_valid_pre", 32'(bus.out_valid), 32'd1);
        pulseReset();
        @(negedge clk);
        #1;
        checkOutput("t5_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t5_busy", 32'(bus.busy), 32'd0);
        checkOutput("t5_tran_en", 32'(bus.tran_en), 32'd0);
        accLog.delete();
        applyStimulus(1, 1, 1'b1);
        waitIdle("t5_idle", 30);
        checkOutput("t5_accepts", 32'(accLog.size()), 32'd2);
        if (accLog.size() > 0) checkOutput("t5_first_grant", 32'(accLog[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
